fir_bank_seq_ctrl: RTL
======================

Name: fir_bank_seq_ctrl

Overview:
- Parametrised sequencing controller for the transposed/direct FIR datapath with NUM_BANK coefficient SRAM banks of TAPS_PER_BANK taps each.
- Loads coefficients from a host write stream and routes each write to the correct bank and address using an internal coefficient counter.
- Per input sample, sweeps all banks in parallel through the tap addresses, drives accumulator enables delayed by the RAM read latency, and flags when the sum is valid.
- Sits between the host/top-level and the SRAM banks, accumulators and sample delay line.

Parameters:
- NUM_BANK, 4, number of coefficient SRAM banks / accumulator lanes (≥1).
- TAPS_PER_BANK, 10, coefficients stored per bank (≥2).
- ADDR_W, 4, bank address width; must satisfy 2^ADDR_W ≥ TAPS_PER_BANK.
- DATA_W, 16, signed coefficient width.
- RD_LAT, 1, SRAM read latency in cycles (≥1).

Ports:
- iClk_12M  in  1  system clock, rising edge.
- iRst  in  1  asynchronous reset, active-high.
- iCoeffiUpdateFlag  in  1  level; requests/holds coefficient load mode.
- iCsnRam  in  1  host chip select, active-low.
- iWrnRam  in  1  host write enable, active-low.
- iWrDtRam  in  DATA_W  signed coefficient write data.
- iInValid  in  1  one-cycle pulse: new input sample present.
- oCsnRam  out  NUM_BANK  per-bank chip select, active-low; bit b = bank b.
- oWrnRam  out  NUM_BANK  per-bank write enable, active-low.
- oAddrRam  out  NUM_BANK*ADDR_W  per-bank address, slice [b*ADDR_W +: ADDR_W].
- oWrDtRam  out  NUM_BANK*DATA_W  per-bank write data, slice [b*DATA_W +: DATA_W].
- oEnAcc  out  NUM_BANK  per-lane accumulator enable.
- oEnDelay  out  1  one-cycle shift pulse to the sample delay line.
- oSumValid  out  1  one-cycle pulse: accumulator sums complete.
- oLoadDone  out  1  level: all NUM_BANK*TAPS_PER_BANK coefficients loaded.
- oLoadErr  out  1  sticky: write attempted beyond the last coefficient.
- oSmpDrop  out  1  sticky: sample lost due to overrun.
- oState  out  2  current FSM state encoding.

Behaviour:
- Reset, asynchronous, any state:
  - oCsnRam and oWrnRam all 1; oAddrRam, oWrDtRam and oEnAcc all 0.
  - oEnDelay, oSumValid, oLoadDone, oLoadErr and oSmpDrop all 0.
  - State IDLE; all counters, the pending flag and the enable pipeline cleared.
  - Reset mid-load or mid-sweep discards all progress; the loaded status is lost.
- Write strobe (wstb) = !iCsnRam && !iWrnRam.
- FSM states: IDLE=0, LOAD=1, RUN=2, SUM=3.
- IDLE:
  - iCoeffiUpdateFlag=1 → LOAD. This has priority over iInValid.
  - Else iInValid=1 && oLoadDone=1 → RUN.
  - iInValid while not loaded is ignored.
- LOAD, on entry:
  - Clear the bank index, address counter, oLoadDone and oLoadErr.
- LOAD, each wstb while fewer than TOTAL = NUM_BANK*TAPS_PER_BANK writes have been accepted:
  - The current bank b gets oCsnRam[b]=0, oWrnRam[b]=0, addr = address counter, data = iWrDtRam. All are combinational in the same cycle; other banks stay idle with addr/data 0.
  - Address counter increments; on reaching TAPS_PER_BANK it wraps to 0 and the bank index increments.
  - The TOTAL-th accepted write sets oLoadDone=1 on the following cycle.
- LOAD, wstb after TOTAL writes: no bank is selected and oLoadErr is set.
- LOAD → IDLE when iCoeffiUpdateFlag=0. A partial load leaves oLoadDone=0.
- RUN:
  - Entry cycle: oEnDelay=1 for one cycle and the tap counter starts at 0.
  - Every cycle: all oCsnRam=0, all oWrnRam=1, and every bank's address = tap counter.
  - Stays exactly TAPS_PER_BANK cycles, then → SUM.
- oEnAcc: every lane equals the "in RUN" indicator delayed by RD_LAT cycles through a shift register.
- SUM:
  - Lasts RD_LAT+1 cycles; banks are deselected.
  - oSumValid=1 on the final SUM cycle only.
  - Exit: → RUN if the pending flag is set (the flag clears), else → IDLE.
- Latency: with iInValid in cycle k,
  - RUN occupies k+1 to k+TAPS_PER_BANK;
  - oEnAcc is high k+1+RD_LAT to k+TAPS_PER_BANK+RD_LAT;
  - oSumValid fires at k+TAPS_PER_BANK+RD_LAT+1.
- Overrun:
  - iInValid during RUN or SUM sets the pending flag.
  - iInValid while the flag is already set, with no exit consuming it that cycle, sets oSmpDrop.
- iCoeffiUpdateFlag during RUN or SUM:
  - The current sweep completes.
  - At SUM exit, the pending flag is cleared (and oSmpDrop set if it was set), then → IDLE, then LOAD on the next cycle.
- oState shows the registered state.

Test Plan:
- Load 40 writes of data n+1 (n=0..39) with default params:
  - write 11 (n=10) → oCsnRam=4'b1101, oWrnRam=4'b1101, bank1 addr 0, data 0x000B;
  - write 40 → bank3 addr 9; oLoadDone=1 on the next cycle.
- After a complete load, issue a 41st wstb → oCsnRam stays 4'b1111 and oLoadErr=1.
  - Re-entering LOAD clears both oLoadDone and oLoadErr.
- Loaded, iInValid in cycle k:
  - oEnDelay pulse at k+1;
  - all four addresses count 0..9 over k+1..k+10;
  - oEnAcc=4'hF over k+2..k+11;
  - a single oSumValid at k+12.
- Overrun:
  - iInValid at k, then k+3 → second sweep starts at k+13 with no IDLE cycle; oSmpDrop stays 0.
  - An extra iInValid at k+5 → oSmpDrop=1.
- Gating:
  - iInValid with oLoadDone=0 → stays IDLE with no bank activity.
  - iCoeffiUpdateFlag=1 mid-RUN → sweep and oSumValid complete, then IDLE → LOAD.
- Assert iRst mid-RUN → outputs take their reset values immediately and oLoadDone=0.
  - A subsequent iInValid is ignored until a full reload.

Source files
------------

// File: rtl/fir_bank_seq_ctrl.sv
// fir_bank_seq_ctrl: sequences coefficient loading and per-sample tap sweeps
// across NUM_BANK coefficient SRAM banks feeding parallel accumulator lanes.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a coefficient update request or a new sample
// LOAD  | host writes routed to bank/address by the coefficient counter
// RUN   | all banks read in parallel, one tap address per cycle
// SUM   | draining the RAM read latency; sum valid on the last cycle
module fir_bank_seq_ctrl #(
  parameter int NUM_BANK      = 4,
  parameter int TAPS_PER_BANK = 10,
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 16,
  parameter int RD_LAT        = 1
) (
  input  logic                         iClk_12M,
  input  logic                         iRst,
  input  logic                         iCoeffiUpdateFlag,
  input  logic                         iCsnRam,
  input  logic                         iWrnRam,
  input  logic [DATA_W-1:0]            iWrDtRam,
  input  logic                         iInValid,
  output logic [NUM_BANK-1:0]          oCsnRam,
  output logic [NUM_BANK-1:0]          oWrnRam,
  output logic [NUM_BANK*ADDR_W-1:0]   oAddrRam,
  output logic [NUM_BANK*DATA_W-1:0]   oWrDtRam,
  output logic [NUM_BANK-1:0]          oEnAcc,
  output logic                         oEnDelay,
  output logic                         oSumValid,
  output logic                         oLoadDone,
  output logic                         oLoadErr,
  output logic                         oSmpDrop,
  output logic [1:0]                   oState
);

  localparam int BANK_W = $clog2(NUM_BANK + 1);
  localparam int SUM_W  = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_SUM  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   tap_q, tap_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [RD_LAT-1:0]   acc_sr_q, acc_sr_d;
  logic                pend_q, pend_d;
  logic                upd_q, upd_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;

  logic wstb;
  logic load_full;
  logic wr_acc;
  logic last_tap;
  logic last_sum;
  logic upd_any;

  assign wstb      = !iCsnRam && !iWrnRam;
  assign load_full = (bank_q == BANK_W'(NUM_BANK));
  assign wr_acc    = (state_q == S_LOAD) && wstb && !load_full;
  assign last_tap  = (tap_q == ADDR_W'(TAPS_PER_BANK - 1));
  assign last_sum  = (sum_q == SUM_W'(RD_LAT));
  assign upd_any   = upd_q || iCoeffiUpdateFlag;

  // Next-state, counter and status-flag computation.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    tap_d    = tap_q;
    sum_d    = sum_q;
    pend_d   = pend_q;
    upd_d    = upd_q;
    done_d   = done_q;
    err_d    = err_q;
    drop_d   = drop_q;
    acc_sr_d = RD_LAT'({acc_sr_q, (state_q == S_RUN)});

    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        upd_d  = 1'b0;
        if (iCoeffiUpdateFlag) begin
          state_d = S_LOAD;
          bank_d  = '0;
          addr_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (iInValid && done_q) begin
          state_d = S_RUN;
          tap_d   = '0;
        end
      end

      S_LOAD: begin
        if (wstb) begin
          if (!load_full) begin
            if (addr_q == ADDR_W'(TAPS_PER_BANK - 1)) begin
              addr_d = '0;
              bank_d = bank_q + BANK_W'(1);
              if (bank_q == BANK_W'(NUM_BANK - 1)) begin
                done_d = 1'b1;
              end
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
        if (!iCoeffiUpdateFlag) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        tap_d = tap_q + ADDR_W'(1);
        if (iCoeffiUpdateFlag) begin
          upd_d = 1'b1;
        end
        if (iInValid) begin
          if (pend_q) begin
            drop_d = 1'b1;
          end
          pend_d = 1'b1;
        end
        if (last_tap) begin
          state_d = S_SUM;
          sum_d   = '0;
        end
      end

      S_SUM: begin
        sum_d = sum_q + SUM_W'(1);
        if (iCoeffiUpdateFlag) begin
          upd_d = 1'b1;
        end
        if (last_sum) begin
          // An update request wins over any queued sample; the queued one is lost.
          if (upd_any) begin
            if (pend_q) begin
              drop_d = 1'b1;
            end
            pend_d  = 1'b0;
            upd_d   = 1'b0;
            state_d = S_IDLE;
          end else if (pend_q || iInValid) begin
            // Exit consumes the queued sample; a sample arriving now becomes the next one.
            state_d = S_RUN;
            tap_d   = '0;
            pend_d  = pend_q && iInValid;
          end else begin
            state_d = S_IDLE;
          end
        end else if (iInValid) begin
          if (pend_q) begin
            drop_d = 1'b1;
          end
          pend_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Single register bank for FSM state, counters and sticky status.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      bank_q   <= '0;
      addr_q   <= '0;
      tap_q    <= '0;
      sum_q    <= '0;
      acc_sr_q <= '0;
      pend_q   <= 1'b0;
      upd_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      tap_q    <= tap_d;
      sum_q    <= sum_d;
      acc_sr_q <= acc_sr_d;
      pend_q   <= pend_d;
      upd_q    <= upd_d;
      done_q   <= done_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  // Bank-side strobes: write routing in LOAD, broadcast tap read in RUN.
  always_comb begin
    oCsnRam  = '1;
    oWrnRam  = '1;
    oAddrRam = '0;
    oWrDtRam = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (wr_acc && (bank_q == BANK_W'(b))) begin
        oCsnRam[b]                  = 1'b0;
        oWrnRam[b]                  = 1'b0;
        oAddrRam[b*ADDR_W +: ADDR_W] = addr_q;
        oWrDtRam[b*DATA_W +: DATA_W] = iWrDtRam;
      end else if (state_q == S_RUN) begin
        oCsnRam[b]                  = 1'b0;
        oAddrRam[b*ADDR_W +: ADDR_W] = tap_q;
      end
    end
  end

  assign oEnAcc    = {NUM_BANK{acc_sr_q[RD_LAT-1]}};
  assign oEnDelay  = (state_q == S_RUN) && (tap_q == '0);
  assign oSumValid = (state_q == S_SUM) && last_sum;
  assign oLoadDone = done_q;
  assign oLoadErr  = err_q;
  assign oSmpDrop  = drop_q;
  assign oState    = state_q;

endmodule
